right_shift_pipelined_barrel: RTL and testbench
===============================================

// Module: right_shift_pipelined_barrel
//
// PURPOSE
// - Parameterised N-bit right shifter with a variable shift amount.
// - Logical (zero-fill) or arithmetic (sign-fill) mode, selected per transaction.
// - Built as a log2(N)-stage pipelined barrel shifter with valid/ready on both sides.
// - Complements the fixed-amount shift blocks. Used wherever a datapath needs a
//   runtime right shift at one result per clock.
//
// PARAMETERS
// - N  8  Data width. Must be a power of two and >= 2.
// - W  $clog2(N) (localparam)  Shift-amount width. Also the number of pipeline stages.
//
// PORTS
// - clk         in   1    Clock. All state updates on the rising edge.
// - rst_n       in   1    Asynchronous reset, active low.
// - up_valid    in   1    Input transaction valid.
// - up_ready    out  1    Block can accept this cycle.
// - up_data     in   N    Operand, unsigned bit vector.
// - up_shamt    in   W    Shift amount, 0..N-1.
// - up_arith    in   1    1 = arithmetic (sign-fill), 0 = logical (zero-fill).
// - down_valid  out  1    Result valid.
// - down_ready  in   1    Consumer accepts the result this cycle.
// - down_data   out  N    Shifted result.
//
// BEHAVIOUR
// - Reset (rst_n low, asynchronous): clear all stage valid, data, shamt and arith
//   registers.
//   - Result: down_valid=0, down_data=0.
//   - up_ready is 1 in the first cycle after reset release.
// - Handshake:
//   - Transfer happens when valid && ready at a rising edge.
//   - Once up_valid is asserted, it may not be dropped before transfer.
//     The bench enforces this on the upstream side.
//   - The block keeps down_valid and down_data stable while down_valid && !down_ready.
// - Stage k (k = 0..W-1): if shamt bit (W-1-k) is set, shift right by 2^(W-1-k).
//   - Fill bit = data[N-1] of the ORIGINAL operand when arith=1, else 0.
//   - The sign bit is carried in each stage register alongside arith.
// - Pipeline advance rule:
//   - Stage k loads from stage k-1 (or from the up_* ports for k=0) when
//     !valid_k || ready_{k+1}.
//   - ready_W = down_ready.
//   - up_ready = ready_0. This is a combinational chain; no skid buffer.
// - Latency: exactly W cycles from an up transfer to down_valid, with no stall.
// - Throughput: 1 result per cycle while down_ready=1.
// - Order is preserved. No transaction is dropped or duplicated.
// - Boundaries:
//   - shamt=0: result equals the operand, in both modes.
//   - shamt=N-1, arith: result is all copies of the sign bit.
//   - Full pipeline with down_ready=0: up_ready=0. Exactly W transactions are held.
//   - Same-cycle down transfer and up transfer on a full pipeline: every stage
//     advances, up_ready=1.
//   - Reset mid-flight: all in-flight transactions are discarded, with no partial
//     output.
//
// STRUCTURE
// - Shared package shift_pkg:
//   - function right_shift_ref(data, shamt, arith), the golden model used by the
//     bench.
//   - typedef struct stage_t { logic valid; logic [N-1:0] data;
//     logic [W-1:0] shamt; logic sign; logic arith; }.
//     This is parameterised via the module; the package holds the field-width
//     convention only.
// - One sub-module, right_shift_stage #(N, W, K):
//   - Holds one stage register, its combinational conditional shift, and the
//     valid/ready advance logic.
//   - Instantiated W times in a generate-for loop.
//
// TESTING (N=8, W=3 unless noted)
// 1. up_data=8'b1011_0110, shamt=3, arith=0, down_ready=1
//    -> down_valid exactly 3 cycles later, down_data=8'b0001_0110.
// 2. Same operand, arith=1 -> down_data=8'b1111_0110.
//    Operand 8'b0011_0110, arith=1 -> 8'b0000_0110.
// 3. Corner values:
//    - 8'h80, shamt=7, arith=1 -> 8'hFF.
//    - 8'h80, shamt=7, arith=0 -> 8'h01.
//    - 8'hA5, shamt=0 -> 8'hA5 in both modes.
// 4. 200 back-to-back random transactions, down_ready=1
//    -> one result per cycle after 3-cycle fill.
//    Each result equals right_shift_ref, in order.
// 5. Stream in 5 transactions with down_ready=0 for 6 cycles:
//    - Up_ready drops after the 3rd accept.
//    - down_data holds stable.
//    - On down_ready=1, all 5 drain in order with no loss or duplicate.
//    - Repeat with random down_ready toggling (50%).
// 6. rst_n pulsed low for 1 cycle with 3 transactions in flight:
//    - down_valid=0 immediately, without waiting for a clock edge.
//    - No pre-reset result ever appears afterwards.
//    - A new transaction after release emerges 3 cycles later.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared helpers for the pipelined right shifter: the per-stage shift distance
// and a width-generic reference shift used as the golden model.
package shift_pkg;
  localparam int MAX_N = 64;

  // Stage register layout (MSB first): {valid, data[N], shamt[W], sign, arith}.
  // The struct itself lives in the modules because N and W are module parameters.

  function automatic int stage_shift(input int w, input int k);
    return 1 << (w - 1 - k);
  endfunction

  function automatic logic [MAX_N-1:0] right_shift_ref(input logic [MAX_N-1:0] data,
                                                        input int shamt,
                                                        input logic arith,
                                                        input int n);
    logic [MAX_N-1:0] res;
    logic fill;
    res  = '0;
    fill = arith & data[6'(n - 1)];
    for (int i = 0; i < MAX_N; i++)
      if (i < n) res[i] = (i + shamt < n) ? data[6'(i + shamt)] : fill;
    return res;
  endfunction
endpackage

// File: rtl/right_shift_pipelined_barrel_stage.sv
// One barrel stage: conditional shift by 2^(W-1-K) feeding a registered slot
// that advances whenever it is empty or the next slot can take its contents.
module right_shift_stage
  import shift_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3,
  parameter int K = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  input  logic [W-1:0] in_shamt,
  input  logic         in_sign,
  input  logic         in_arith,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic [W-1:0] out_shamt,
  output logic         out_sign,
  output logic         out_arith
);
  localparam int SH = stage_shift(W, K);

  typedef struct packed {
    logic         valid;
    logic [N-1:0] data;
    logic [W-1:0] shamt;
    logic         sign;
    logic         arith;
  } stage_t;

  stage_t       stage_q, stage_d;
  logic         load;
  logic         fill;
  logic [N-1:0] shifted;

  always_comb begin
    load    = !stage_q.valid || out_ready;
    fill    = in_arith & in_sign;
    shifted = in_data;
    // Fill comes from the original operand's MSB, carried down as in_sign.
    if (in_shamt[W-1-K]) shifted = (in_data >> SH) | ({N{fill}} << (N - SH));
    stage_d = stage_q;
    if (load) begin
      stage_d.valid = in_valid;
      if (in_valid) begin
        stage_d.data  = shifted;
        stage_d.shamt = in_shamt;
        stage_d.sign  = in_sign;
        stage_d.arith = in_arith;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign out_valid = stage_q.valid;
  assign out_data  = stage_q.data;
  assign out_shamt = stage_q.shamt;
  assign out_sign  = stage_q.sign;
  assign out_arith = stage_q.arith;
endmodule

// File: rtl/right_shift_pipelined_barrel.sv
// Runtime logical/arithmetic right shifter, log2(N) registered stages with
// valid/ready on both sides. N must be a power of two and at least 2.
module right_shift_pipelined_barrel
  import shift_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [N-1:0] up_data,
  input  logic [W-1:0] up_shamt,
  input  logic         up_arith,
  output logic         down_valid,
  input  logic         down_ready,
  output logic [N-1:0] down_data
);
  logic [W:0]          vld, rdy, sgn, ari;
  logic [W:0][N-1:0]   dat;
  logic [W:0][W-1:0]   sha;
  logic                unused_tail;

  assign vld[0] = up_valid;
  assign dat[0] = up_data;
  assign sha[0] = up_shamt;
  assign sgn[0] = up_data[N-1];
  assign ari[0] = up_arith;
  assign rdy[W] = down_ready;

  for (genvar k = 0; k < W; k++) begin : g_stage
    // Slot k can load iff the output accepts or some slot at or after k is empty;
    // written in closed form so the ready chain has no self-referencing vector.
    assign rdy[k] = down_ready | ~(&vld[W:k+1]);

    right_shift_stage #(.N(N), .W(W), .K(k)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld[k]),
      .in_data   (dat[k]),
      .in_shamt  (sha[k]),
      .in_sign   (sgn[k]),
      .in_arith  (ari[k]),
      .out_ready (rdy[k+1]),
      .out_valid (vld[k+1]),
      .out_data  (dat[k+1]),
      .out_shamt (sha[k+1]),
      .out_sign  (sgn[k+1]),
      .out_arith (ari[k+1])
    );
  end

  assign up_ready    = rdy[0];
  assign down_valid  = vld[W];
  assign down_data   = dat[W];
  assign unused_tail = ^{sha[W], sgn[W], ari[W]};
endmodule

// File: tb/tb_right_shift_pipelined_barrel.sv
// Directed and random checks of the pipelined right shifter (N=8) against a
// queue-based arithmetic model, plus literal expectations for key vectors.
module tb_right_shift_pipelined_barrel;
  import shift_pkg::*;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 0, rst_n = 0;
  logic         up_valid = 0, up_arith = 0, down_ready = 1;
  logic [N-1:0] up_data = '0;
  logic [W-1:0] up_shamt = '0;
  logic         up_ready, down_valid;
  logic [N-1:0] down_data;

  always #5 clk = ~clk;

  right_shift_pipelined_barrel #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .up_shamt(up_shamt), .up_arith(up_arith),
    .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data)
  );

  int checks = 0, passes = 0;
  int neg_cnt = 0, n_acc = 0, n_out = 0;
  logic [7:0] exp_q[$];
  int         t_q[$];
  bit         chk_lat = 1;
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;
  logic [7:0] mon_e;
  int         mon_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] mdl(input logic [7:0] d, input logic [2:0] s, input logic a);
    logic signed [7:0] sd;
    sd = d;
    if (a) return 8'(sd >>> s);
    return d >> s;
  endfunction

  // Scoreboard: every up transfer queues its expected result; every down
  // transfer must match the head, in order, W cycles later when unstalled.
  always @(negedge clk) begin
    neg_cnt++;
    if (!rst_n) begin
      exp_q.delete();
      t_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(down_valid), 32'd1);
        chk("hold_data", 32'(down_data), 32'(prev_data));
      end
      if (down_valid && down_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'(down_valid), 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          mon_t = t_q.pop_front();
          chk("data", 32'(down_data), 32'(mon_e));
          if (chk_lat) chk("latency", neg_cnt - mon_t, W);
          n_out++;
        end
      end
      if (up_valid && up_ready) begin
        exp_q.push_back(mdl(up_data, up_shamt, up_arith));
        t_q.push_back(neg_cnt);
        n_acc++;
      end
      prev_stall = down_valid && !down_ready;
      prev_data  = down_data;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic a);
    int g;
    g = 0;
    up_valid = 1; up_data = d; up_shamt = s; up_arith = a;
    @(negedge clk);
    while (!up_ready && g < 500) begin @(negedge clk); g++; end
    if (g >= 500) chk("send_timeout", 32'(up_ready), 32'd1);
    @(posedge clk); #1;
    up_valid = 0;
  endtask

  task automatic run1(input string nm, input logic [7:0] d, input logic [2:0] s,
                      input logic a, input logic [7:0] e);
    int k;
    send(d, s, a);
    @(negedge clk); k = 1;
    while (!down_valid && k < 20) begin @(negedge clk); k++; end
    chk({nm, "_data"}, 32'(down_data), 32'(e));
    chk({nm, "_lat"}, k, 3);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string nm);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || down_valid) && g < 200) begin @(negedge clk); g++; end
    chk(nm, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  bit tog = 0;
  bit snd_done = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, o0, t0, g;
    logic [7:0] d;
    logic [2:0] s;
    logic a;

    // Reset state, during and right after release
    @(posedge clk); #1;
    chk("rst_valid", 32'(down_valid), 32'd0);
    chk("rst_data", 32'(down_data), 32'd0);
    @(posedge clk); #3 rst_n = 1;
    @(negedge clk);
    chk("rel_valid", 32'(down_valid), 32'd0);
    chk("rel_data", 32'(down_data), 32'd0);
    chk("rel_up_ready", 32'(up_ready), 32'd1);
    @(posedge clk); #1;

    // Pin the bench model and the package reference with hand-computed values
    chk("pin_mdl_log", 32'(mdl(8'hB6, 3'd3, 1'b0)), 32'h16);
    chk("pin_mdl_ari", 32'(mdl(8'hB6, 3'd3, 1'b1)), 32'hF6);
    chk("pin_mdl_pos", 32'(mdl(8'h36, 3'd3, 1'b1)), 32'h06);
    chk("pin_ref_ari", 32'(right_shift_ref(64'hB6, 3, 1'b1, 8)), 32'hF6);
    chk("pin_ref_max", 32'(right_shift_ref(64'h80, 7, 1'b1, 8)), 32'hFF);

    // Directed vectors, single transactions
    run1("t1_log",    8'b1011_0110, 3'd3, 1'b0, 8'b0001_0110);
    run1("t2_ari",    8'b1011_0110, 3'd3, 1'b1, 8'b1111_0110);
    run1("t2_arip",   8'b0011_0110, 3'd3, 1'b1, 8'b0000_0110);
    run1("t3_80ari",  8'h80, 3'd7, 1'b1, 8'hFF);
    run1("t3_80log",  8'h80, 3'd7, 1'b0, 8'h01);
    run1("t3_a5log",  8'hA5, 3'd0, 1'b0, 8'hA5);
    run1("t3_a5ari",  8'hA5, 3'd0, 1'b1, 8'hA5);

    // 200 back-to-back random transactions
    o0 = n_out; t0 = neg_cnt;
    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom); s = 3'($urandom); a = 1'($urandom);
      if (i < 16) chk("ref_vs_mdl", 32'(right_shift_ref(64'(d), int'(s), a, 8)), 32'(mdl(d, s, a)));
      send(d, s, a);
    end
    chk("b2b_cycles", neg_cnt - t0, 200);
    wait_drain("t4_drain");
    chk("t4_count", n_out - o0, 200);

    // Stall with down_ready low: exactly W held, up_ready drops, then drain
    chk_lat = 0;
    down_ready = 0;
    a0 = n_acc; o0 = n_out; snd_done = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(8'(8'h91 + 8'(i * 17)), 3'(i + 1), 1'(i));
        snd_done = 1;
      end
    join_none
    repeat (6) @(negedge clk);
    chk("t5_held", n_acc - a0, W);
    chk("t5_up_ready", 32'(up_ready), 32'd0);
    chk("t5_valid", 32'(down_valid), 32'd1);
    @(posedge clk); #1 down_ready = 1;
    g = 0;
    while (!snd_done && g < 100) begin @(posedge clk); g++; end
    chk("t5_senders", 32'(snd_done), 32'd1);
    wait_drain("t5_drain");
    chk("t5_count", n_out - o0, 5);

    // Random down_ready toggling with random upstream gaps
    o0 = n_out; tog = 1;
    fork
      while (tog) begin @(posedge clk); #1 down_ready = 1'($urandom_range(0, 1)); end
    join_none
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 3'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    tog = 0;
    @(posedge clk); #2 down_ready = 1;
    wait_drain("t5r_drain");
    chk("t5r_count", n_out - o0, 40);
    chk_lat = 1;

    // Reset with three transactions in flight
    send(8'h11, 3'd1, 1'b0);
    send(8'h22, 3'd2, 1'b0);
    send(8'h84, 3'd2, 1'b1);
    chk("t6_inflight", 32'(down_valid), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("t6_async_valid", 32'(down_valid), 32'd0);
    chk("t6_async_data", 32'(down_data), 32'd0);
    #9 rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_stale", 32'(down_valid), 32'd0);
    end
    @(posedge clk); #1;
    run1("t6_new", 8'hC3, 3'd2, 1'b1, 8'hF0);
    wait_drain("final_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
